// File: rtl/duc_model_path_pkg.sv
// Shared types and constants for the DUC model path-string helpers.
// path_t is the packed NUL-padded string used by the join stream and the truncation helper.
package duc_model_path_pkg;

  localparam int unsigned MAX_BYTES = 512;
  localparam logic [7:0]  SEP_CHAR  = 8'h2F;
  localparam logic [7:0]  NUL_CHAR  = 8'h00;

  typedef logic [8*MAX_BYTES-1:0] path_t;

  typedef enum logic [2:0] {IDLE, BASE, SEP, LEAF, TERM} state_t;

  // Keep the first `keep` bytes of a path and NUL-fill the rest.
  function automatic path_t path_truncate(path_t p, int unsigned keep);
    path_t r;
    r = '0;
    for (int unsigned k = 0; k < MAX_BYTES; k++) begin
      if (k < keep) r[8*k +: 8] = p[8*k +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/duc_model_path_byte_sel.sv
// Combinational byte picker for a packed NUL-padded string.
// Indices at or beyond MAX_BYTES read as NUL so the caller's end-of-string test covers both cases.
module duc_model_path_byte_sel #(
  parameter int unsigned MAX_BYTES = 512,
  parameter int unsigned CNT_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic [8*MAX_BYTES-1:0] str_i,
  input  logic [CNT_W-1:0]       idx_i,
  output logic [7:0]             byte_o,
  output logic                   is_nul_o
);

  always_comb begin
    byte_o = 8'h00;
    if (32'(idx_i) < MAX_BYTES) byte_o = str_i[8*idx_i +: 8];
    is_nul_o = (byte_o == 8'h00);
  end

endmodule

// File: rtl/duc_model_path_join_stream.sv
// Streams "base/leaf" as NUL-terminated bytes over a valid/ready handshake.
// Segment skips and the overflow cut are resolved combinationally, so no bubble cycles appear.
module duc_model_path_join_stream
  import duc_model_path_pkg::*;
#(
  parameter int unsigned MAX_BYTES = duc_model_path_pkg::MAX_BYTES,
  parameter logic [7:0]  SEP_CHAR  = duc_model_path_pkg::SEP_CHAR,
  parameter int unsigned CNT_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic                   clk,
  input  logic                   areset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [8*MAX_BYTES-1:0] req_base,
  input  logic [8*MAX_BYTES-1:0] req_leaf,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             out_data,
  output logic                   out_last,
  output logic [CNT_W-1:0]       out_len,
  output logic                   out_ovf
);

  localparam logic [CNT_W-1:0] OcntMax = CNT_W'(MAX_BYTES - 1);

  state_t                 state_q, state_d, eff_state;
  logic [CNT_W-1:0]       bidx_q, bidx_d, lidx_q, lidx_d, ocnt_q, ocnt_d;
  logic                   last_sep_q, last_sep_d;
  logic [8*MAX_BYTES-1:0] base_q, base_d, leaf_q, leaf_d;
  logic [7:0]             base_byte, leaf_byte;
  logic                   base_nul, leaf_nul, ovf, xfer;

  duc_model_path_byte_sel #(.MAX_BYTES(MAX_BYTES), .CNT_W(CNT_W)) u_base_sel (
    .str_i    (base_q),
    .idx_i    (bidx_q),
    .byte_o   (base_byte),
    .is_nul_o (base_nul)
  );

  duc_model_path_byte_sel #(.MAX_BYTES(MAX_BYTES), .CNT_W(CNT_W)) u_leaf_sel (
    .str_i    (leaf_q),
    .idx_i    (lidx_q),
    .byte_o   (leaf_byte),
    .is_nul_o (leaf_nul)
  );

  always_ff @(posedge clk) begin
    if (areset) begin
      state_q    <= IDLE;
      bidx_q     <= '0;
      lidx_q     <= '0;
      ocnt_q     <= '0;
      last_sep_q <= 1'b0;
      base_q     <= '0;
      leaf_q     <= '0;
    end else begin
      state_q    <= state_d;
      bidx_q     <= bidx_d;
      lidx_q     <= lidx_d;
      ocnt_q     <= ocnt_d;
      last_sep_q <= last_sep_d;
      base_q     <= base_d;
      leaf_q     <= leaf_d;
    end
  end

  // Effective state: the registered state after skipping empty segments and applying the cut.
  always_comb begin
    eff_state = state_q;
    ovf       = 1'b0;
    if (state_q == BASE && base_nul) begin
      eff_state = (bidx_q == '0 || last_sep_q) ? LEAF : SEP;
    end
    if (eff_state == LEAF && leaf_nul) eff_state = TERM;
    if (eff_state inside {BASE, SEP, LEAF} && ocnt_q == OcntMax) begin
      eff_state = TERM;
      ovf       = 1'b1;
    end
  end

  assign xfer = out_valid && out_ready;

  always_comb begin
    state_d    = state_q;
    bidx_d     = bidx_q;
    lidx_d     = lidx_q;
    ocnt_d     = ocnt_q;
    last_sep_d = last_sep_q;
    base_d     = base_q;
    leaf_d     = leaf_q;
    unique case (eff_state)
      IDLE: begin
        if (req_valid) begin
          state_d    = BASE;
          bidx_d     = '0;
          lidx_d     = '0;
          ocnt_d     = '0;
          last_sep_d = 1'b0;
          base_d     = req_base;
          leaf_d     = req_leaf;
        end
      end
      BASE: begin
        if (xfer) begin
          bidx_d     = bidx_q + 1'b1;
          ocnt_d     = ocnt_q + 1'b1;
          last_sep_d = (base_byte == SEP_CHAR);
        end
      end
      SEP: begin
        if (xfer) begin
          state_d = LEAF;
          lidx_d  = '0;
          ocnt_d  = ocnt_q + 1'b1;
        end
      end
      LEAF: begin
        if (xfer) begin
          state_d = LEAF;
          lidx_d  = lidx_q + 1'b1;
          ocnt_d  = ocnt_q + 1'b1;
        end
      end
      TERM: begin
        if (xfer) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (eff_state == IDLE);
    out_valid = (eff_state != IDLE);
    out_last  = (eff_state == TERM);
    out_ovf   = (eff_state == TERM) && ovf;
    out_len   = ocnt_q;
    out_data  = NUL_CHAR;
    unique case (eff_state)
      BASE:    out_data = base_byte;
      SEP:     out_data = SEP_CHAR;
      LEAF:    out_data = leaf_byte;
      default: out_data = NUL_CHAR;
    endcase
  end

endmodule

// File: tb/tb_duc_model_path_join_stream.sv
// Directed bench for the path join stream: a 512-byte instance and an 8-byte instance for the cut.
module tb_duc_model_path_join_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic areset, req_valid, out_ready, use_b;
  logic [4095:0] req_base, req_leaf;

  logic a_req_valid, a_req_ready, a_out_valid, a_out_last, a_out_ovf;
  logic [7:0] a_out_data;
  logic [9:0] a_out_len;
  logic b_req_valid, b_req_ready, b_out_valid, b_out_last, b_out_ovf;
  logic [7:0] b_out_data;
  logic [3:0] b_out_len;

  assign a_req_valid = req_valid & ~use_b;
  assign b_req_valid = req_valid & use_b;

  duc_model_path_join_stream u_dut_a (
    .clk(clk), .areset(areset), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_base(req_base), .req_leaf(req_leaf), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_data(a_out_data), .out_last(a_out_last), .out_len(a_out_len), .out_ovf(a_out_ovf)
  );

  duc_model_path_join_stream #(.MAX_BYTES(8)) u_dut_b (
    .clk(clk), .areset(areset), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_base(req_base[63:0]), .req_leaf(req_leaf[63:0]), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_data(b_out_data), .out_last(b_out_last), .out_len(b_out_len),
    .out_ovf(b_out_ovf)
  );

  logic       m_req_ready, m_out_valid, m_out_last, m_out_ovf;
  logic [7:0] m_out_data;
  logic [9:0] m_out_len;
  assign m_req_ready = use_b ? b_req_ready : a_req_ready;
  assign m_out_valid = use_b ? b_out_valid : a_out_valid;
  assign m_out_last  = use_b ? b_out_last  : a_out_last;
  assign m_out_ovf   = use_b ? b_out_ovf   : a_out_ovf;
  assign m_out_data  = use_b ? b_out_data  : a_out_data;
  assign m_out_len   = use_b ? {6'd0, b_out_len} : a_out_len;

  int passed = 0;
  int total  = 0;
  logic [7:0] exp_q[$];

  function automatic logic [4095:0] pack(input string s);
    logic [4095:0] v;
    v = '0;
    for (int i = 0; i < s.len(); i++) v[8*i +: 8] = s[i];
    return v;
  endfunction

  // Issues one request, then follows the stream beat by beat against exp_q.
  task automatic run_case(input string name, input string base, input string leaf,
                          input int exp_len, input logic exp_ovf, input bit toggle, input bit bsel);
    int n, cyc;
    bit stalled;
    logic [7:0] held;
    use_b = bsel;
    out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (m_req_ready !== 1'b1) $display("FAIL %s idle_ready: got %b want 1", name, m_req_ready);
    else passed++;
    req_base = pack(base);
    req_leaf = pack(leaf);
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    req_base = '0;
    req_leaf = '0;
    n = 0;
    cyc = 0;
    stalled = 0;
    held = 8'h00;
    while (n < exp_q.size() && cyc < 100) begin
      out_ready = toggle ? (cyc % 3 == 0) : 1'b1;
      total++;
      if (m_out_valid !== 1'b1) $display("FAIL %s valid beat%0d: got %b want 1", name, n, m_out_valid);
      else passed++;
      total++;
      if (m_req_ready !== 1'b0) $display("FAIL %s busy_ready: got %b want 0", name, m_req_ready);
      else passed++;
      if (stalled) begin
        total++;
        if (m_out_data !== held) $display("FAIL %s stall_hold: got %h want %h", name, m_out_data, held);
        else passed++;
      end
      if (out_ready) begin
        total++;
        if (m_out_data !== exp_q[n] || m_out_last !== (n == exp_q.size() - 1))
          $display("FAIL %s beat%0d: got %h/last%b want %h/last%b", name, n, m_out_data,
                   m_out_last, exp_q[n], (n == exp_q.size() - 1));
        else passed++;
        if (n == exp_q.size() - 1) begin
          total++;
          if (m_out_len !== 10'(exp_len) || m_out_ovf !== exp_ovf)
            $display("FAIL %s len_ovf: got %0d/%b want %0d/%b", name, m_out_len, m_out_ovf,
                     exp_len, exp_ovf);
          else passed++;
        end
        n++;
        stalled = 0;
      end else begin
        stalled = 1;
        held = m_out_data;
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b1;
    total++;
    if (n != exp_q.size()) $display("FAIL %s timeout: got %0d beats want %0d", name, n, exp_q.size());
    else passed++;
    total++;
    if (m_out_valid !== 1'b0 || m_req_ready !== 1'b1)
      $display("FAIL %s back_idle: got valid%b ready%b want valid0 ready1", name, m_out_valid,
               m_req_ready);
    else passed++;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    req_valid = 1'b0;
    out_ready = 1'b1;
    use_b = 1'b0;
    req_base = '0;
    req_leaf = '0;
    repeat (2) @(negedge clk);
    total++;
    if (a_req_ready !== 1'b1 || a_out_valid !== 1'b0 || a_out_last !== 1'b0 || a_out_ovf !== 1'b0
        || a_out_data !== 8'h00 || a_out_len !== 10'd0)
      $display("FAIL reset_a: got rdy%b v%b l%b o%b d%h n%0d want 1 0 0 0 00 0", a_req_ready,
               a_out_valid, a_out_last, a_out_ovf, a_out_data, a_out_len);
    else passed++;
    total++;
    if (b_req_ready !== 1'b1 || b_out_valid !== 1'b0 || b_out_last !== 1'b0 || b_out_ovf !== 1'b0
        || b_out_data !== 8'h00 || b_out_len !== 4'd0)
      $display("FAIL reset_b: got rdy%b v%b l%b o%b d%h n%0d want 1 0 0 0 00 0", b_req_ready,
               b_out_valid, b_out_last, b_out_ovf, b_out_data, b_out_len);
    else passed++;
    areset = 1'b0;
  endtask

  task automatic test_basic_join();
    exp_q = '{8'h61, 8'h62, 8'h63, 8'h2F, 8'h78, 8'h2E, 8'h74, 8'h78, 8'h74, 8'h00};
    run_case("abc_xtxt", "abc", "x.txt", 9, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_empty_segments();
    exp_q = '{8'h66, 8'h00};
    run_case("empty_base", "", "f", 1, 1'b0, 1'b0, 1'b0);
    exp_q = '{8'h00};
    run_case("both_empty", "", "", 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_separator();
    exp_q = '{8'h64, 8'h2F, 8'h66, 8'h00};
    run_case("base_slash", "d/", "f", 3, 1'b0, 1'b0, 1'b0);
    exp_q = '{8'h61, 8'h2F, 8'h2F, 8'h62, 8'h00};
    run_case("leaf_slash", "a", "/b", 4, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    exp_q = '{8'h61, 8'h62, 8'h63, 8'h2F, 8'h78, 8'h2E, 8'h74, 8'h78, 8'h74, 8'h00};
    run_case("stall", "abc", "x.txt", 9, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_overflow();
    exp_q = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h2F, 8'h65, 8'h66, 8'h00};
    run_case("ovf8", "abcd", "efgh", 7, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid_stream();
    logic [7:0] want[3];
    want = '{8'h61, 8'h62, 8'h63};
    use_b = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    req_base = pack("abc");
    req_leaf = pack("x.txt");
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (a_out_valid !== 1'b1 || a_out_data !== want[i])
        $display("FAIL mid_beat%0d: got v%b %h want v1 %h", i, a_out_valid, a_out_data, want[i]);
      else passed++;
      @(negedge clk);
    end
    areset = 1'b1;
    @(negedge clk);
    total++;
    if (a_out_valid !== 1'b0 || a_req_ready !== 1'b1)
      $display("FAIL mid_reset: got valid%b ready%b want valid0 ready1", a_out_valid, a_req_ready);
    else passed++;
    areset = 1'b0;
    exp_q = '{8'h71, 8'h2F, 8'h72, 8'h00};
    run_case("after_reset", "q", "r", 3, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic_join();
    test_empty_segments();
    test_separator();
    test_backpressure();
    test_overflow();
    test_reset_mid_stream();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
